// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-requester burst RAM read arbiter.
package ram_arb_pkg;
  localparam int DEF_LEN_W  = 2;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  // Requester index: 0 or 1.
  typedef logic req_idx_t;
endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin pick; on a tie the requester that did not win last time goes first.
module rr_arbiter_2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   last,
  output logic       gnt_vld,
  output req_idx_t   gnt_idx
);

  always_comb begin
    gnt_vld = |req;
    gnt_idx = 1'b0;
    case (req)
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Burst read arbiter: grants one of two requesters, streams Len+1 consecutive RAM words,
// and tags the returned data with the owning requester one edge after each address.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int LEN_W  = DEF_LEN_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [1:0]        Req,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [LEN_W-1:0]  Len0,
  input  logic [LEN_W-1:0]  Len1,
  output logic [1:0]        Ack,
  output logic [1:0]        Rvalid,
  output logic [DATA_W-1:0] Rdata,
  output logic              Busy,
  output logic [ADDR_W-1:0] Ram_Address,
  input  logic [DATA_W-1:0] Ram_Data
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  len_g;
  logic [1:0]        ack_d, rvalid_d;
  logic              issue_q, issue_d;
  req_idx_t          owner_q, owner_d;
  req_idx_t          last_q, last_d;
  logic [1:0]        eligible;
  logic              gnt_vld;
  req_idx_t          gnt_idx;

  // A requester whose Ack is still visible may not have dropped Req yet; mask it to avoid a double grant.
  assign eligible = Req & ~Ack;

  rr_arbiter_2 u_rr (
    .req     (eligible),
    .last    (last_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  assign len_g = gnt_idx ? Len1 : Len0;

  always_comb begin
    state_d  = state_q;
    addr_d   = Ram_Address;
    ack_d    = 2'b00;
    rem_d    = rem_q;
    owner_d  = owner_q;
    issue_d  = 1'b0;
    last_d   = last_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          addr_d  = gnt_idx ? Addr1 : Addr0;
          ack_d   = gnt_idx ? 2'b10 : 2'b01;
          rem_d   = len_g;
          owner_d = gnt_idx;
          issue_d = 1'b1;
          last_d  = gnt_idx;
          if (len_g != '0) state_d = BURST;
        end
      end
      BURST: begin
        addr_d  = Ram_Address + 1'b1;
        rem_d   = rem_q - 1'b1;
        issue_d = 1'b1;
        if (rem_q == LEN_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Owner changes together with the address it tags, so the data one edge later carries the right tag.
    rvalid_d = issue_q ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      Ram_Address <= '0;
      Ack         <= 2'b00;
      Rvalid      <= 2'b00;
      issue_q     <= 1'b0;
      rem_q       <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      Ram_Address <= addr_d;
      Ack         <= ack_d;
      Rvalid      <= rvalid_d;
      issue_q     <= issue_d;
      rem_q       <= rem_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
    end
  end

  assign Rdata = (|Rvalid) ? Ram_Data : '0;
  assign Busy  = (state_q == BURST) | issue_q | (|Rvalid);

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter LEN_W, default 2: burst-length field width; burst = Len+1 words (1..4).
REQ-002 Parameter ADDR_W, default 5: RAM address width (32 words).
REQ-003 Parameter DATA_W, default 8: RAM data width.
REQ-004 Clock  in  1  single clock; all state on posedge Clock.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 Req  in  2  per-requester read request; held until own Ack.
REQ-007 Addr0, Addr1  in  ADDR_W each  start address per requester.
REQ-008 Len0, Len1  in  LEN_W each  burst length minus one per requester.
REQ-009 Ack  out  2  one-cycle pulse; burst of that requester accepted.
REQ-010 Rvalid  out  2  read data valid, tagged to owning requester.
REQ-011 Rdata  out  DATA_W  shared read data.
REQ-012 Busy  out  1  burst in progress or read in flight.
REQ-013 Ram_Address  out  ADDR_W  registered address to RAM.
REQ-014 Ram_Data  in  DATA_W  RAM output, valid one edge after address sampled.

Function
REQ-015 FSM states IDLE and BURST only.
REQ-016 IDLE, edge with any eligible Req: grant winner g; Ram_Address<=Addr_g; Ack[g]<=1; Remaining<=Len_g; Owner<=g; Issue<=1.
REQ-017 IDLE -> BURST when Len_g != 0; stays IDLE when Len_g == 0 (next grant possible at following edge).
REQ-018 BURST, each edge: Ram_Address<=Ram_Address+1 modulo 2^ADDR_W (31 wraps to 0); Remaining<=Remaining-1; Issue<=1; Req ignored.
REQ-019 BURST -> IDLE at the edge issuing the last word (Remaining==1).
REQ-020 Issue deasserts at any edge in IDLE with no grant.
REQ-021 Rvalid[Owner]<=Issue at each edge; Rvalid is the Issue pipeline delayed one edge, aligning with Ram_Data.
REQ-022 Latency: Req sampled at edge k -> Ack high cycle k+1 -> first Rvalid high cycle k+2; burst words on consecutive cycles.
REQ-023 Rdata = Ram_Data while any Rvalid high, else all zeros.
REQ-024 Arbitration round-robin: single eligible request wins; both eligible -> requester != Last wins; Last<=g on every grant.
REQ-025 Req[g] ineligible at any edge where Ack[g] is high (no double grant from late Req drop).
REQ-026 Ack never high for both requesters; Ack pulses exactly once per burst.
REQ-027 Busy = (state==BURST) | Issue | any Rvalid.
REQ-028 Max throughput one word per cycle; back-to-back single-word grants alternate under contention.

Reset
REQ-029 Reset asserted: state=IDLE, Ram_Address=0, Ack=0, Rvalid=0, Issue=0, Remaining=0, Owner=0, Last=1, Busy=0, asynchronously.
REQ-030 Reset mid-burst or with read in flight: pending words discarded; no Rvalid after release until a new grant.
REQ-031 First edge after Reset release may grant; tie then goes to requester 0.

Structure
REQ-032 Package ram_arb_pkg holds state enum (IDLE, BURST), ADDR_W/DATA_W/LEN_W defaults, requester-index type.
REQ-033 Sub-module rr_arbiter_2: combinational pick from eligible Req and Last, returns grant-valid and index.
REQ-034 All other logic (FSM, counter, address incrementer, Rvalid pipeline) in ram_arbiter.

Verification
REQ-035 Bench: team ram instance, hex file word i = 8'hA0+i; compare every Rvalid/Rdata against it.
REQ-036 Req=01, Addr0=3, Len0=0 at edge k -> Ack=01 cycle k+1; Rvalid=01, Rdata=8'hA3 cycle k+2; Busy low cycle k+3.
REQ-037 Req=10, Addr1=30, Len1=3 -> Rvalid=10 four consecutive cycles, Rdata A+1E, A+1F, A0, A1 (wrap 31->0).
REQ-038 Req=11 held after reset, both Len=0, Addr0=1, Addr1=2 -> grants 0,1,0,1...; Rdata A1,A2,A1,A2 tagged 01,10.
REQ-039 Req0 burst Len0=3 running, Req1 rises mid-burst -> Ack[1] only on edge after last word of requester 0 issued; no gap in Rdata stream.
REQ-040 Reset pulse two cycles into a 4-word burst -> all outputs zero immediately; no further Rvalid; next Req=01 served normally with Ack at k+1.
